// File: rtl/ntt_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ntt_seq_ctrl : layer/pair sequencer for one radix-2 NTT/INTT butterfly.   |
// | Optional cyc_cnt output under NTT_SEQ_CTRL_CYCCNT_EN.   Rev 1.0           |
// +--------------------------------------------------------------------------+
module ntt_seq_ctrl #(
  parameter int LOGN   = 8,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mode_in,
  output logic            busy,
  output logic            done,
  output logic [1:0]      bf_mode,
  output logic [2:0]      layer,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tw_idx,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
`ifdef NTT_SEQ_CTRL_CYCCNT_EN
  ,
  output logic [15:0]     cyc_cnt
`endif
);

  localparam int D  = RD_LAT + BF_LAT;
  localparam int DW = (D > 1) ? $clog2(D) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [LOGN-2:0] P_LAST     = '1;
  localparam logic [LOGN-2:0] ONES       = '1;
  localparam logic [2:0]      LAST_LAYER = 3'(LOGN - 2);
  localparam logic [DW-1:0]   D_LAST     = DW'(D - 1);

  logic [1:0]      state, state_n;
  logic [LOGN-2:0] p, p_n;
  logic [2:0]      layer_n;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic            inv, inv_n;

  int              shamt;
  logic [LOGN-2:0] g, j;
  logic [LOGN-1:0] addr_a_n, addr_b_n;
  logic [LOGN-2:0] tw_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      p     <= '0;
      layer <= '0;
      dcnt  <= '0;
      inv   <= 1'b0;
    end else begin
      state <= state_n;
      p     <= p_n;
      layer <= layer_n;
      dcnt  <= dcnt_n;
      inv   <= inv_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    p_n     = p;
    layer_n = layer;
    dcnt_n  = dcnt;
    inv_n   = inv;
    case (state)
      S_IDLE: begin
        if (start && !mode_in[1]) begin
          state_n = S_RUN;
          p_n     = '0;
          layer_n = '0;
          inv_n   = mode_in[0];
        end
      end
      S_RUN: begin
        if (p == P_LAST) begin
          state_n = S_DRAIN;
          dcnt_n  = '0;
        end else begin
          p_n = p + (LOGN-1)'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt == D_LAST) begin
          if (layer < LAST_LAYER) begin
            state_n = S_RUN;
            layer_n = layer + 3'd1;
            p_n     = '0;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy    = (state == S_RUN) || (state == S_DRAIN);
    done    = (state == S_DONE);
    bf_mode = busy ? {1'b0, inv} : 2'b11;
  end

  // Addresses for the pair about to be issued; shamt = log2(len) so g/j split p.
  always_comb begin
    shamt    = inv_n ? (int'(layer_n) + 1) : (LOGN - 1 - int'(layer_n));
    g        = p_n >> shamt;
    j        = p_n & (ONES >> (LOGN - 1 - shamt));
    addr_a_n = ({1'b0, g} << (shamt + 1)) + {1'b0, j};
    addr_b_n = addr_a_n + (LOGN'(1) << shamt);
    tw_n     = inv_n ? ((ONES >> layer_n) - g) : (((LOGN-1)'(1) << layer_n) + g);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
    end else begin
      rd_en <= (state_n == S_RUN);
      if (state_n == S_RUN) begin
        rd_addr_a <= addr_a_n;
        rd_addr_b <= addr_b_n;
        tw_idx    <= tw_n;
      end
    end
  end

  // Write-back delay line: stage D-1 lines up with the butterfly output.
  logic            dly_v [D];
  logic [LOGN-1:0] dly_a [D];
  logic [LOGN-1:0] dly_b [D];

  generate
    for (genvar i = 0; i < D; i++) begin : g_dly
      if (i == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            dly_v[i] <= 1'b0;
            dly_a[i] <= '0;
            dly_b[i] <= '0;
          end else begin
            dly_v[i] <= rd_en;
            dly_a[i] <= rd_addr_a;
            dly_b[i] <= rd_addr_b;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            dly_v[i] <= 1'b0;
            dly_a[i] <= '0;
            dly_b[i] <= '0;
          end else begin
            dly_v[i] <= dly_v[i-1];
            dly_a[i] <= dly_a[i-1];
            dly_b[i] <= dly_b[i-1];
          end
        end
      end
    end
  endgenerate

  assign wr_en     = dly_v[D-1];
  assign wr_addr_a = dly_a[D-1];
  assign wr_addr_b = dly_b[D-1];

`ifdef NTT_SEQ_CTRL_CYCCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if ((state == S_IDLE) && (state_n == S_RUN)) begin
      cyc_cnt <= '0;
    end else if (busy) begin
      cyc_cnt <= cyc_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ntt_seq_ctrl : scoreboard bench for the NTT/INTT sequencer.   Rev 1.0  |
// +--------------------------------------------------------------------------+
module tb_ntt_seq_ctrl;

  localparam int LOGN     = 8;
  localparam int N        = 1 << LOGN;
  localparam int D        = 5;
  localparam int BUSY_CYC = 931;
  localparam int ISSUES   = 896;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      mode_in = 2'b00;
  logic            busy, done, rd_en, wr_en;
  logic [1:0]      bf_mode;
  logic [2:0]      layer;
  logic [LOGN-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOGN-2:0] tw_idx;
`ifdef NTT_SEQ_CTRL_CYCCNT_EN
  logic [15:0]     cyc_cnt;
`endif

  ntt_seq_ctrl #(.LOGN(LOGN), .RD_LAT(1), .BF_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in),
    .busy(busy), .done(done), .bf_mode(bf_mode), .layer(layer),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
`ifdef NTT_SEQ_CTRL_CYCCNT_EN
    , .cyc_cnt(cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LOGN-1:0] a;
    logic [LOGN-1:0] b;
    logic [LOGN-2:0] tw;
    logic [2:0]      lay;
  } iss_t;
  typedef struct {
    logic [LOGN-1:0] a;
    logic [LOGN-1:0] b;
    int              due;
  } wb_t;

  iss_t exp_q[$];
  wb_t  wb_q[$];
  iss_t mon_e;
  wb_t  mon_w;

  int         checks = 0, errors = 0, cyc = 0;
  int         busy_cnt = 0, done_cnt = 0, wr_cnt = 0, iss_cnt = 0;
  bit         mon_en = 1'b0;
  logic [1:0] exp_mode = 2'b00;

  always @(posedge clk) cyc++;

  // Reference: textbook Kyber loops, k walks the twiddle table
  task automatic gen_expected(input logic [1:0] m);
    int   k, lay;
    iss_t e;
    lay = 0;
    if (m == 2'b00) begin
      k = 1;
      for (int len = N/2; len >= 2; len = len >> 1) begin
        for (int st = 0; st < N; st += 2*len) begin
          for (int jj = st; jj < st + len; jj++) begin
            e.a = LOGN'(jj); e.b = LOGN'(jj + len); e.tw = (LOGN-1)'(k); e.lay = 3'(lay);
            exp_q.push_back(e);
          end
          k++;
        end
        lay++;
      end
    end else begin
      k = N/2 - 1;
      for (int len = 2; len <= N/2; len = len << 1) begin
        for (int st = 0; st < N; st += 2*len) begin
          for (int jj = st; jj < st + len; jj++) begin
            e.a = LOGN'(jj); e.b = LOGN'(jj + len); e.tw = (LOGN-1)'(k); e.lay = 3'(lay);
            exp_q.push_back(e);
          end
          k--;
        end
        lay++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (wr_en) wr_cnt++;
      if (rd_en) begin
        iss_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL issue_extra: got a=%0d b=%0d tw=%0d, no issue expected", rd_addr_a, rd_addr_b, tw_idx);
        end else begin
          mon_e = exp_q.pop_front();
          if (rd_addr_a !== mon_e.a || rd_addr_b !== mon_e.b || tw_idx !== mon_e.tw ||
              layer !== mon_e.lay || bf_mode !== exp_mode) begin
            errors++;
            $display("FAIL issue_%0d: got a=%0d b=%0d tw=%0d layer=%0d mode=%b, want a=%0d b=%0d tw=%0d layer=%0d mode=%b",
                     iss_cnt - 1, rd_addr_a, rd_addr_b, tw_idx, layer, bf_mode,
                     mon_e.a, mon_e.b, mon_e.tw, mon_e.lay, exp_mode);
          end
          mon_w.a = mon_e.a; mon_w.b = mon_e.b; mon_w.due = cyc + D;
          wb_q.push_back(mon_w);
        end
      end
      if (wb_q.size() != 0 && wb_q[0].due == cyc) begin
        checks++;
        mon_w = wb_q.pop_front();
        if (wr_en !== 1'b1 || wr_addr_a !== mon_w.a || wr_addr_b !== mon_w.b) begin
          errors++;
          $display("FAIL writeback: got en=%b a=%0d b=%0d, want en=1 a=%0d b=%0d at cycle %0d",
                   wr_en, wr_addr_a, wr_addr_b, mon_w.a, mon_w.b, cyc);
        end
      end else if (wr_en !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got wr_en=%b a=%0d b=%0d at cycle %0d, want wr_en=0", wr_en, wr_addr_a, wr_addr_b, cyc);
      end
    end
  end

  task automatic launch(input logic [1:0] m);
    gen_expected(m);
    exp_mode = m;
    busy_cnt = 0; done_cnt = 0; wr_cnt = 0; iss_cnt = 0;
    start = 1'b1; mode_in = m;
    @(negedge clk);
    start = 1'b0; mode_in = m ^ 2'b01;
  endtask

  task automatic finish_op(input string name, input bit poke);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_done: done not seen within 1500 cycles, want pulse", name); end
`ifdef NTT_SEQ_CTRL_CYCCNT_EN
    checks++;
    if (cyc_cnt !== 16'd931) begin errors++; $display("FAIL %s_cyccnt: got %0d, want 931", name, cyc_cnt); end
`endif
    if (poke) begin start = 1'b1; mode_in = 2'b00; end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bf_mode !== 2'b11) begin
      errors++;
      $display("FAIL %s_after_done: got done=%b busy=%b mode=%b, want 0 0 11", name, done, busy, bf_mode);
    end
    @(negedge clk);
    checks++;
    if (busy_cnt !== BUSY_CYC) begin errors++; $display("FAIL %s_busy_cycles: got %0d, want %0d", name, busy_cnt, BUSY_CYC); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL %s_done_pulses: got %0d, want 1", name, done_cnt); end
    checks++;
    if (wr_cnt !== ISSUES) begin errors++; $display("FAIL %s_wr_pulses: got %0d, want %0d", name, wr_cnt, ISSUES); end
    checks++;
    if (exp_q.size() != 0 || wb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d issues %0d writes outstanding, want 0 0", name, exp_q.size(), wb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode_in = 2'b00;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({busy, done, rd_en, wr_en, bf_mode, layer} !== {4'b0000, 2'b11, 3'd0}) begin
        errors++;
        $display("FAIL reset_ctrl_%0d: got busy=%b done=%b rd=%b wr=%b mode=%b layer=%0d, want 0 0 0 0 11 0",
                 k, busy, done, rd_en, wr_en, bf_mode, layer);
      end
      checks++;
      if ({rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b} !== '0) begin
        errors++;
        $display("FAIL reset_addr_%0d: got ra=%0d rb=%0d tw=%0d wa=%0d wb=%0d, want all 0",
                 k, rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b);
      end
      rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_ntt();
    launch(2'b00);
    checks++;
    if (rd_en !== 1'b1 || rd_addr_a !== 8'd0 || rd_addr_b !== 8'd128 || tw_idx !== 7'd1 ||
        bf_mode !== 2'b00 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL ntt_first: got rd=%b a=%0d b=%0d tw=%0d mode=%b wr=%b, want 1 0 128 1 00 0",
               rd_en, rd_addr_a, rd_addr_b, tw_idx, bf_mode, wr_en);
    end
    finish_op("ntt", 1'b0);
  endtask

  task automatic test_intt();
    launch(2'b01);
    checks++;
    if (rd_en !== 1'b1 || rd_addr_a !== 8'd0 || rd_addr_b !== 8'd2 || tw_idx !== 7'd127 || bf_mode !== 2'b01) begin
      errors++;
      $display("FAIL intt_first: got rd=%b a=%0d b=%0d tw=%0d mode=%b, want 1 0 2 127 01",
               rd_en, rd_addr_a, rd_addr_b, tw_idx, bf_mode);
    end
    finish_op("intt", 1'b0);
  endtask

  task automatic test_ignore();
    launch(2'b00);
    repeat (200) @(negedge clk);
    start = 1'b1; mode_in = 2'b01;
    @(negedge clk);
    start = 1'b0; mode_in = 2'b00;
    finish_op("ignore", 1'b1);
    for (int m = 2; m < 4; m++) begin
      start = 1'b1; mode_in = 2'(m);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || bf_mode !== 2'b11) begin
        errors++;
        $display("FAIL bad_mode_%0d: got busy=%b rd=%b mode=%b, want 0 0 11", m, busy, rd_en, bf_mode);
      end
    end
  endtask

  task automatic test_reset_midop();
    bit hit;
    hit = 1'b0;
    launch(2'b00);
    for (int i = 0; i < 1000; i++) begin
      if (iss_cnt >= 3*128 + 51) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!hit || layer !== 3'd3 || rd_en !== 1'b1) begin
      errors++;
      $display("FAIL midop_reach: got hit=%b layer=%0d rd=%b, want 1 3 1", hit, layer, rd_en);
    end
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd_en, wr_en, bf_mode, layer} !== {4'b0000, 2'b11, 3'd0} ||
        {rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b} !== '0) begin
      errors++;
      $display("FAIL midop_reset: got busy=%b rd=%b wr=%b mode=%b layer=%0d ra=%0d rb=%0d tw=%0d, want reset values",
               busy, rd_en, wr_en, bf_mode, layer, rd_addr_a, rd_addr_b, tw_idx);
    end
    exp_q.delete();
    wb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_cnt = 0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (wr_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_release: got wr pulses=%0d busy=%b, want 0 0", wr_cnt, busy);
    end
    launch(2'b00);
    finish_op("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_ntt();
    test_intt();
    test_ignore();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
